// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for an in-order integer pipeline: tracks per-stage valid/tags,
// drives EX forwarding selects, load-use stalls, multi-cycle EX holds and redirect flushes.
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int REG_ADDR_W = 5,
    parameter int MUL_LAT    = 6,
    parameter int FWD_SEL_W  = $clog2(NUM_STAGES-2)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic                  id_rs_use,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rt_use,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_we,
    input  logic                  id_is_load,
    input  logic                  id_is_multi,
    input  logic                  ex_redirect,
    output logic                  if_en,
    output logic                  id_en,
    output logic                  ex_busy,
    output logic                  load_use_stall,
    output logic [FWD_SEL_W-1:0]  ex_fwd_a_sel,
    output logic [FWD_SEL_W-1:0]  ex_fwd_b_sel,
    output logic [NUM_STAGES-1:0] stage_valid
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT-1);

    logic                  v0, v1;
    logic [NUM_STAGES-1:2] s_valid;
    logic [NUM_STAGES-1:2] s_we;
    logic [REG_ADDR_W-1:0] s_rd [NUM_STAGES-1:2];
    logic                  ex_load, ex_multi;
    logic [REG_ADDR_W-1:0] ex_rs, ex_rt;
    logic                  ex_rs_use, ex_rt_use;
    logic [CNT_W-1:0]      mul_cnt;

    logic                  busy_int, ex_adv, lus_int, redir, adv_en;
    logic [FWD_SEL_W-1:0]  sel_a, sel_b;

    always_comb begin
        busy_int = s_valid[2] & ex_multi & (mul_cnt != '0);
        ex_adv   = ~busy_int;
        lus_int  = v1 & ex_adv & s_valid[2] & ex_load & s_we[2] & (s_rd[2] != '0) &
                   ((id_rs_use & (id_rs == s_rd[2])) | (id_rt_use & (id_rt == s_rd[2])));
        redir    = ex_adv & s_valid[2] & ex_redirect;
        adv_en   = ex_adv & (redir | ~lus_int);
    end

    // Walk oldest to youngest so the youngest matching producer overwrites the select.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = NUM_STAGES-3; k >= 1; k--) begin
            if (s_valid[2+k] & s_we[2+k] & (s_rd[2+k] != '0)) begin
                if (ex_rs_use & (s_rd[2+k] == ex_rs)) sel_a = FWD_SEL_W'(k);
                if (ex_rt_use & (s_rd[2+k] == ex_rt)) sel_b = FWD_SEL_W'(k);
            end
        end
    end

    assign if_en          = ~reset & adv_en;
    assign id_en          = ~reset & adv_en;
    assign ex_busy        = ~reset & busy_int;
    assign load_use_stall = ~reset & lus_int;
    assign ex_fwd_a_sel   = reset ? '0 : sel_a;
    assign ex_fwd_b_sel   = reset ? '0 : sel_b;
    assign stage_valid    = {s_valid, v1, v0};

    // Stages past EX keep only what forwarding reads; load/multi matter only in EX.
    always_ff @(posedge clock) begin
        if (reset) begin
            v0        <= 1'b0;
            v1        <= 1'b0;
            s_valid   <= '0;
            s_we      <= '0;
            for (int i = 2; i < NUM_STAGES; i++) s_rd[i] <= '0;
            ex_load   <= 1'b0;
            ex_multi  <= 1'b0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rs_use <= 1'b0;
            ex_rt_use <= 1'b0;
            mul_cnt   <= '0;
        end else begin
            v0 <= 1'b1;
            if (redir)       v1 <= 1'b0;
            else if (adv_en) v1 <= v0;

            if (ex_adv) begin
                if (redir | lus_int | ~v1) begin
                    s_valid[2] <= 1'b0;
                    s_we[2]    <= 1'b0;
                    s_rd[2]    <= '0;
                    ex_load    <= 1'b0;
                    ex_multi   <= 1'b0;
                    ex_rs      <= '0;
                    ex_rt      <= '0;
                    ex_rs_use  <= 1'b0;
                    ex_rt_use  <= 1'b0;
                    mul_cnt    <= '0;
                end else begin
                    s_valid[2] <= 1'b1;
                    s_we[2]    <= id_reg_we;
                    s_rd[2]    <= id_rd;
                    ex_load    <= id_is_load;
                    ex_multi   <= id_is_multi;
                    ex_rs      <= id_rs;
                    ex_rt      <= id_rt;
                    ex_rs_use  <= id_rs_use;
                    ex_rt_use  <= id_rt_use;
                    mul_cnt    <= id_is_multi ? CNT_LOAD : '0;
                end
            end else begin
                mul_cnt <= mul_cnt - 1'b1;
            end

            // During a multi hold stage 3 takes bubbles so older work keeps draining.
            s_valid[3] <= ex_adv & s_valid[2];
            s_we[3]    <= ex_adv & s_we[2];
            s_rd[3]    <= ex_adv ? s_rd[2] : '0;
            for (int i = 4; i < NUM_STAGES; i++) begin
                s_valid[i] <= s_valid[i-1];
                s_we[i]    <= s_we[i-1];
                s_rd[i]    <= s_rd[i-1];
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a hand-derived per-cycle vector table on the 5-stage build
// through a scoreboard queue, plus a short 7-stage sequence for deep forwarding.
module tb_pipe_hazard_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, reset7;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_rs_use, id_rt_use, id_reg_we, id_is_load, id_is_multi, ex_redirect;
    logic       if_en, id_en, ex_busy, load_use_stall;
    logic [1:0] fwd_a, fwd_b;
    logic [4:0] stage_valid;

    logic [4:0] rs7, rt7, rd7;
    logic       rs_use7, rt_use7, we7, load7, multi7, redirect7;
    logic       if_en7, id_en7, busy7, lus7;
    logic [2:0] fwd_a7, fwd_b7;
    logic [6:0] stage_valid7;

    pipe_hazard_ctrl dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rs_use(id_rs_use), .id_rt(id_rt), .id_rt_use(id_rt_use),
        .id_rd(id_rd), .id_reg_we(id_reg_we), .id_is_load(id_is_load), .id_is_multi(id_is_multi),
        .ex_redirect(ex_redirect), .if_en(if_en), .id_en(id_en), .ex_busy(ex_busy),
        .load_use_stall(load_use_stall), .ex_fwd_a_sel(fwd_a), .ex_fwd_b_sel(fwd_b),
        .stage_valid(stage_valid)
    );

    pipe_hazard_ctrl #(.NUM_STAGES(7), .MUL_LAT(1)) dut7 (
        .clock(clock), .reset(reset7),
        .id_rs(rs7), .id_rs_use(rs_use7), .id_rt(rt7), .id_rt_use(rt_use7),
        .id_rd(rd7), .id_reg_we(we7), .id_is_load(load7), .id_is_multi(multi7),
        .ex_redirect(redirect7), .if_en(if_en7), .id_en(id_en7), .ex_busy(busy7),
        .load_use_stall(lus7), .ex_fwd_a_sel(fwd_a7), .ex_fwd_b_sel(fwd_b7),
        .stage_valid(stage_valid7)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs;  logic rsu;
        logic [4:0] rt;  logic rtu;
        logic [4:0] rd;  logic we, ld, mul, rdr;
        logic       en, lus, busy;
        logic [1:0] fa, fb;
        logic [4:0] sv;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic [4:0] rd,
                       input logic we, input logic ld, input logic mul, input logic rdr,
                       input logic en, input logic lus, input logic busy,
                       input logic [1:0] fa, input logic [1:0] fb, input logic [4:0] sv);
        vec_t v;
        v.rst = rst; v.rs = rs; v.rsu = rsu; v.rt = rt; v.rtu = rtu; v.rd = rd;
        v.we = we; v.ld = ld; v.mul = mul; v.rdr = rdr;
        v.en = en; v.lus = lus; v.busy = busy; v.fa = fa; v.fb = fb; v.sv = sv;
        vecs.push_back(v);
    endtask

    task automatic drive7(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                          input logic rtu, input logic [4:0] rd, input logic we, input logic mul);
        rs7 = rs; rs_use7 = rsu; rt7 = rt; rt_use7 = rtu; rd7 = rd; we7 = we; multi7 = mul;
    endtask

    initial begin
        vec_t v, e;
        // rst  rs rsu rt rtu rd we ld mul rdr | en lus busy fa fb  stage_valid
        add(1,  0,0,  0,0,  0, 0,0,0,0,   0,0,0, 0,0, 5'b00000);
        add(0,  0,0,  0,0,  0, 0,0,0,0,   1,0,0, 0,0, 5'b00000);
        add(0,  0,0,  0,0,  0, 0,0,0,0,   1,0,0, 0,0, 5'b00001);
        add(0,  1,1,  2,1,  3, 1,0,0,0,   1,0,0, 0,0, 5'b00011);
        add(0,  3,1,  1,1,  4, 1,0,0,0,   1,0,0, 0,0, 5'b00111);
        add(0, 10,1, 11,1,  9, 1,0,0,0,   1,0,0, 1,0, 5'b01111);
        add(0,  1,1,  4,1, 12, 1,0,0,0,   1,0,0, 0,0, 5'b11111);
        add(0,  5,1,  6,1,  0, 1,0,0,0,   1,0,0, 0,2, 5'b11111);
        add(0,  0,1, 12,1, 13, 1,0,0,0,   1,0,0, 0,0, 5'b11111);
        add(0,  1,1,  0,0,  5, 1,1,0,0,   1,0,0, 0,2, 5'b11111);
        add(0,  5,1,  5,1,  6, 1,0,0,0,   0,1,0, 0,0, 5'b11111);
        add(0,  5,1,  5,1,  6, 1,0,0,0,   1,0,0, 0,0, 5'b11011);
        add(0,  1,1,  2,1,  7, 1,0,1,0,   1,0,0, 2,2, 5'b10111);
        add(0,  7,1,  1,1,  8, 1,0,0,0,   0,0,1, 0,0, 5'b01111);
        add(0,  7,1,  1,1,  8, 1,0,0,0,   0,0,1, 0,0, 5'b10111);
        add(0,  7,1,  1,1,  8, 1,0,0,1,   0,0,1, 0,0, 5'b00111);
        add(0,  7,1,  1,1,  8, 1,0,0,0,   0,0,1, 0,0, 5'b00111);
        add(0,  7,1,  1,1,  8, 1,0,0,0,   0,0,1, 0,0, 5'b00111);
        add(0,  7,1,  1,1,  8, 1,0,0,0,   1,0,0, 0,0, 5'b00111);
        add(0,  1,1,  2,1, 20, 1,0,0,1,   1,0,0, 1,0, 5'b01111);
        add(0,  0,0,  0,0,  0, 0,0,0,0,   1,0,0, 0,0, 5'b11001);
        add(0,  1,1,  0,0,  9, 1,1,0,0,   1,0,0, 0,0, 5'b10011);
        add(0,  9,1,  0,0, 10, 1,0,0,1,   1,1,0, 0,0, 5'b00111);
        add(0,  0,0,  0,0,  0, 0,0,0,0,   1,0,0, 0,0, 5'b01001);
        add(0,  1,1,  2,1,  7, 1,0,1,0,   1,0,0, 0,0, 5'b10011);
        add(0,  0,0,  0,0,  0, 0,0,0,0,   0,0,1, 0,0, 5'b00111);
        add(1,  0,0,  0,0,  0, 0,0,0,0,   0,0,0, 0,0, 5'b00111);
        add(1,  0,0,  0,0,  0, 0,0,0,0,   0,0,0, 0,0, 5'b00000);
        add(1,  0,0,  0,0,  0, 0,0,0,0,   0,0,0, 0,0, 5'b00000);
        add(0,  0,0,  0,0,  0, 0,0,0,0,   1,0,0, 0,0, 5'b00000);
        add(0,  0,0,  0,0,  0, 0,0,0,0,   1,0,0, 0,0, 5'b00001);
        add(0,  0,0,  0,0,  0, 0,0,0,0,   1,0,0, 0,0, 5'b00011);
        add(0,  0,0,  0,0,  0, 0,0,0,0,   1,0,0, 0,0, 5'b00111);
        add(0,  0,0,  0,0,  0, 0,0,0,0,   1,0,0, 0,0, 5'b01111);
        add(0,  0,0,  0,0,  0, 0,0,0,0,   1,0,0, 0,0, 5'b11111);

        reset = 1'b1; reset7 = 1'b1;
        id_rs = '0; id_rt = '0; id_rd = '0;
        id_rs_use = 1'b0; id_rt_use = 1'b0; id_reg_we = 1'b0;
        id_is_load = 1'b0; id_is_multi = 1'b0; ex_redirect = 1'b0;
        drive7(0, 0, 0, 0, 0, 0, 0);
        load7 = 1'b0; redirect7 = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            reset = v.rst;
            id_rs = v.rs; id_rs_use = v.rsu; id_rt = v.rt; id_rt_use = v.rtu;
            id_rd = v.rd; id_reg_we = v.we; id_is_load = v.ld; id_is_multi = v.mul;
            ex_redirect = v.rdr;
            exp_q.push_back(v);
            @(negedge clock);
            e = exp_q.pop_front();
            check($sformatf("vec%0d", i),
                  {3'b000, if_en, id_en, load_use_stall, ex_busy, fwd_a, fwd_b, stage_valid},
                  {3'b000, e.en, e.en, e.lus, e.busy, e.fa, e.fb, e.sv});
            @(posedge clock);
            #1;
        end

        reset7 = 1'b0;
        for (int c = 0; c < 16; c++) begin
            case (c)
                2:       drive7(0, 0, 0, 0, 3, 1, 0);
                6:       drive7(3, 1, 8, 1, 9, 1, 0);
                8, 9, 10, 11: drive7(0, 0, 0, 0, 5, 1, 0);
                12:      drive7(5, 1, 5, 1, 6, 1, 0);
                14:      drive7(0, 0, 0, 0, 0, 0, 1);
                default: drive7(0, 0, 0, 0, 0, 0, 0);
            endcase
            @(negedge clock);
            if (c == 7) begin
                check("n7_valid_full", 16'(stage_valid7), 16'h007F);
                check("n7_fwd_a_deep", 16'(fwd_a7), 16'd4);
                check("n7_fwd_b_none", 16'(fwd_b7), 16'd0);
            end
            if (c == 13) begin
                check("n7_fwd_a_youngest", 16'(fwd_a7), 16'd1);
                check("n7_fwd_b_youngest", 16'(fwd_b7), 16'd1);
            end
            if (c == 15) begin
                check("n7_mullat1_busy", 16'(busy7), 16'd0);
                check("n7_mullat1_if_en", 16'(if_en7), 16'd1);
            end
            @(posedge clock);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
